// File: rtl/sdp_ram_pkg.sv
// Shared types and helpers for the byte-enable simple-dual-port RAM.
package sdp_ram_pkg;

  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;

  localparam int unsigned MAX_READ_LATENCY = 2;

  // Number of byte-enable lanes in a word.
  function automatic int unsigned lanes(input int unsigned dw, input int unsigned bw);
    return dw / bw;
  endfunction

endpackage

// File: rtl/sdp_ram_be_if.sv
// Write/read bus of the byte-enable SDP RAM; master drives requests, slave is the RAM.
interface sdp_ram_be_if
  import sdp_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
) ();

  localparam int unsigned NUM_LANES = lanes(DATA_WIDTH, BYTE_WIDTH);

  logic                  init_busy;
  logic                  wr_en;
  logic [NUM_LANES-1:0]  wr_be;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    input  init_busy, rd_valid, rd_data
  );

  modport slave (
    input  wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    output init_busy, rd_valid, rd_data
  );

endinterface

// File: rtl/sdp_ram_be_clear.sv
// Post-reset zero-fill sequencer: walks every address once, then idles.
module sdp_ram_be_clear
  import sdp_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DEPTH          = 1 << ADDR_WIDTH,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  clr_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  busy_q;

  // State, address counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET ? CLR_RUN : CLR_IDLE;
      addr_q  <= '0;
      busy_q  <= CLEAR_ON_RESET;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      busy_q  <= (state_d == CLR_RUN);
    end
  end

  // Advance one word per cycle and stop after the last address.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      CLR_RUN: begin
        if (addr_q == LAST_ADDR) begin
          state_d = CLR_IDLE;
          addr_d  = '0;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = CLR_IDLE;
      end
    endcase
  end

  assign clr_we    = busy_q;
  assign clr_addr  = addr_q;
  assign init_busy = busy_q;

endmodule

// File: rtl/sdp_ram_be.sv
// Single-clock simple-dual-port RAM with byte-lane write enables, 1/2-cycle
// read latency with rd_valid, and an optional post-reset zero fill.
// Build option: SDP_RAM_BE_BYPASS_EN selects write-first forwarding on a
// same-cycle same-address read/write; undefined gives read-first.
module sdp_ram_be
  import sdp_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DEPTH          = 1 << ADDR_WIDTH,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  sdp_ram_be_if.slave bus
);

  localparam int unsigned NUM_LANES = lanes(DATA_WIDTH, BYTE_WIDTH);
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  // Reject illegal configurations at elaboration.
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_err_width
    $error("sdp_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_err_lat
    $error("sdp_ram_be: READ_LATENCY must be 1 or 2");
  end
  if (64'(DEPTH) > (64'(1) << ADDR_WIDTH)) begin : g_err_depth
    $error("sdp_ram_be: DEPTH exceeds 2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  busy;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  m_we;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [NUM_LANES-1:0]  m_be;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_in_range;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] mem_word;
  logic [DATA_WIDTH-1:0] rd_word;

  sdp_ram_be_clear #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk       (clk),
    .rst       (rst),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (busy)
  );

  assign bus.init_busy = busy;
  assign wr_acc        = bus.wr_en & ~busy;
  assign rd_acc        = bus.rd_en & ~busy;

  // Clear sequencer owns the write port while busy; user writes otherwise.
  always_comb begin
    m_we   = wr_acc;
    m_addr = bus.wr_addr;
    m_be   = bus.wr_be;
    m_data = bus.wr_data;
    if (busy) begin
      m_we   = clr_we;
      m_addr = clr_addr;
      m_be   = '1;
      m_data = '0;
    end
  end

  assign m_in_range  = {1'b0, m_addr} < DEPTH_EXT;
  assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_EXT;

  // Byte-lane masked array write; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (m_we && m_in_range) begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        if (m_be[i]) begin
          mem[m_addr[IDX_W-1:0]][i*BYTE_WIDTH +: BYTE_WIDTH] <= m_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  assign mem_word = rd_in_range ? mem[bus.rd_addr[IDX_W-1:0]] : '0;

`ifdef SDP_RAM_BE_BYPASS_EN
  logic collide;

  assign collide = wr_acc && rd_in_range && (bus.wr_addr == bus.rd_addr);

  // Write-first: forward enabled lanes of the concurrent write.
  always_comb begin
    rd_word = mem_word;
    if (collide) begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        if (bus.wr_be[i]) begin
          rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end
`else
  assign rd_word = mem_word;
`endif

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  p_valid;
    logic [DATA_WIDTH-1:0] p_data;

    // Two-stage read pipeline; data registers load only with their valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        p_valid      <= 1'b0;
        p_data       <= '0;
        bus.rd_valid <= 1'b0;
        bus.rd_data  <= '0;
      end else begin
        p_valid      <= rd_acc;
        bus.rd_valid <= p_valid;
        if (rd_acc) begin
          p_data <= rd_word;
        end
        if (p_valid) begin
          bus.rd_data <= p_data;
        end
      end
    end
  end else begin : g_lat1
    // Single-stage read; rd_data holds when no read was accepted.
    always_ff @(posedge clk) begin
      if (rst) begin
        bus.rd_valid <= 1'b0;
        bus.rd_data  <= '0;
      end else begin
        bus.rd_valid <= rd_acc;
        if (rd_acc) begin
          bus.rd_data <= rd_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdp_ram_be.sv
// Directed bench: one latency-1 and one latency-2 RAM (DEPTH 16, 5-bit address)
// driven by the same stimulus.
module tb_sdp_ram_be;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [4:0]  rd_addr;

  int n_vec;
  int n_err;

  sdp_ram_be_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(5)) if1 ();
  sdp_ram_be_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(5)) if2 ();

  assign if1.wr_en   = wr_en;
  assign if1.wr_be   = wr_be;
  assign if1.wr_addr = wr_addr;
  assign if1.wr_data = wr_data;
  assign if1.rd_en   = rd_en;
  assign if1.rd_addr = rd_addr;
  assign if2.wr_en   = wr_en;
  assign if2.wr_be   = wr_be;
  assign if2.wr_addr = wr_addr;
  assign if2.wr_data = wr_data;
  assign if2.rd_en   = rd_en;
  assign if2.rd_addr = rd_addr;

  sdp_ram_be #(
    .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(16),
    .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
  ) u_dut_l1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  sdp_ram_be #(
    .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(16),
    .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
  ) u_dut_l2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_rd;
    logic [4:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(input bit r, input int a, input int b, input logic [31:0] d);
    vec_t v;
    v.is_rd = r;
    v.addr  = 5'(a);
    v.be    = 4'(b);
    v.data  = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single read, checked on both RAMs at their own latency.
  task automatic do_read(input logic [4:0] a, input logic [31:0] exp, input string name);
    rd_en   = 1'b1;
    rd_addr = a;
    step();
    rd_en = 1'b0;
    check_b({name, "/l1_valid"}, if1.rd_valid, 1'b1);
    check({name, "/l1_data"}, if1.rd_data, exp);
    check_b({name, "/l2_early"}, if2.rd_valid, 1'b0);
    step();
    check_b({name, "/l2_valid"}, if2.rd_valid, 1'b1);
    check({name, "/l2_data"}, if2.rd_data, exp);
    check_b({name, "/l1_drop"}, if1.rd_valid, 1'b0);
    check({name, "/l1_hold"}, if1.rd_data, exp);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_be   = be;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Count cycles of init_busy; optionally confirm requests issued meanwhile are ignored.
  task automatic wait_clear(input string name, input bit chk_ign);
    int cnt;
    cnt = 0;
    while (if1.init_busy === 1'b1 && cnt < 100) begin
      step();
      cnt++;
      if (chk_ign) begin
        check_b({name, "/ign_l1"}, if1.rd_valid, 1'b0);
        check_b({name, "/ign_l2"}, if2.rd_valid, 1'b0);
      end
    end
    check({name, "/busy_cycles"}, 32'(cnt), 32'd16);
    check_b({name, "/l2_busy_done"}, if2.init_busy, 1'b0);
  endtask

  logic [31:0] coll_exp;

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_be   = 4'h0;
    wr_addr = 5'd0;
    wr_data = 32'h0;
    rd_en   = 1'b0;
    rd_addr = 5'd0;

    vecs[0]  = mk(1'b0, 5,  4'hF, 32'hDEADBEEF);
    vecs[1]  = mk(1'b0, 5,  4'h5, 32'h11223344);
    vecs[2]  = mk(1'b1, 5,  4'h0, 32'hDE22BE44);
    vecs[3]  = mk(1'b0, 3,  4'h0, 32'hFFFFFFFF);
    vecs[4]  = mk(1'b1, 3,  4'h0, 32'h00000000);
    vecs[5]  = mk(1'b0, 20, 4'hF, 32'h12345678);
    vecs[6]  = mk(1'b1, 4,  4'h0, 32'h00000000);
    vecs[7]  = mk(1'b1, 20, 4'h0, 32'h00000000);
    vecs[8]  = mk(1'b1, 31, 4'h0, 32'h00000000);
    vecs[9]  = mk(1'b0, 9,  4'h8, 32'hA5FFFFFF);
    vecs[10] = mk(1'b1, 9,  4'h0, 32'hA5000000);
    vecs[11] = mk(1'b0, 15, 4'hF, 32'hCAFEF00D);
    vecs[12] = mk(1'b1, 15, 4'h0, 32'hCAFEF00D);
    vecs[13] = mk(1'b0, 15, 4'h2, 32'h00009900);
    vecs[14] = mk(1'b1, 15, 4'h0, 32'hCAFE990D);
    vecs[15] = mk(1'b0, 16, 4'hF, 32'h77777777);
    vecs[16] = mk(1'b1, 0,  4'h0, 32'h00000000);
    vecs[17] = mk(1'b0, 7,  4'hF, 32'hAAAAAAAA);
    vecs[18] = mk(1'b1, 7,  4'h0, 32'hAAAAAAAA);
    vecs[19] = mk(1'b0, 1,  4'hF, 32'h00000101);
    vecs[20] = mk(1'b0, 2,  4'hF, 32'h00000202);
    vecs[21] = mk(1'b0, 3,  4'hF, 32'h00000303);

    // Reset for two cycles, then time the zero-fill.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_b("rst/l1_valid", if1.rd_valid, 1'b0);
    check("rst/l1_data", if1.rd_data, 32'h0);
    check_b("rst/l1_busy", if1.init_busy, 1'b1);
    check_b("rst/l2_valid", if2.rd_valid, 1'b0);
    check("rst/l2_data", if2.rd_data, 32'h0);
    check_b("rst/l2_busy", if2.init_busy, 1'b1);
    rst = 1'b0;
    wait_clear("clear0", 1'b0);

    for (int a = 0; a < 16; a++) begin
      do_read(5'(a), 32'h0, $sformatf("zero%0d", a));
    end

    // Directed write/read table.
    for (int i = 0; i < 22; i++) begin
      if (vecs[i].is_rd) begin
        do_read(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
      end else begin
        do_write(vecs[i].addr, vecs[i].be, vecs[i].data);
      end
    end

    // Back-to-back reads of addresses 1, 2, 3.
    rd_en   = 1'b1;
    rd_addr = 5'd1;
    step();
    check_b("b2b/c1_l1_valid", if1.rd_valid, 1'b1);
    check("b2b/c1_l1_data", if1.rd_data, 32'h101);
    check_b("b2b/c1_l2_valid", if2.rd_valid, 1'b0);
    rd_addr = 5'd2;
    step();
    check_b("b2b/c2_l1_valid", if1.rd_valid, 1'b1);
    check("b2b/c2_l1_data", if1.rd_data, 32'h202);
    check_b("b2b/c2_l2_valid", if2.rd_valid, 1'b1);
    check("b2b/c2_l2_data", if2.rd_data, 32'h101);
    rd_addr = 5'd3;
    step();
    check("b2b/c3_l1_data", if1.rd_data, 32'h303);
    check_b("b2b/c3_l2_valid", if2.rd_valid, 1'b1);
    check("b2b/c3_l2_data", if2.rd_data, 32'h202);
    rd_en = 1'b0;
    step();
    check_b("b2b/c4_l1_valid", if1.rd_valid, 1'b0);
    check("b2b/c4_l1_hold", if1.rd_data, 32'h303);
    check_b("b2b/c4_l2_valid", if2.rd_valid, 1'b1);
    check("b2b/c4_l2_data", if2.rd_data, 32'h303);
    step();
    check_b("b2b/c5_l2_valid", if2.rd_valid, 1'b0);
    check("b2b/c5_l2_hold", if2.rd_data, 32'h303);

    // Same-cycle read and write of address 7.
`ifdef SDP_RAM_BE_BYPASS_EN
    coll_exp = 32'h55555555;
`else
    coll_exp = 32'hAAAAAAAA;
`endif
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_be   = 4'hF;
    wr_data = 32'h55555555;
    rd_en   = 1'b1;
    rd_addr = 5'd7;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_b("coll/l1_valid", if1.rd_valid, 1'b1);
    check("coll/l1_data", if1.rd_data, coll_exp);
    step();
    check_b("coll/l2_valid", if2.rd_valid, 1'b1);
    check("coll/l2_data", if2.rd_data, coll_exp);
    do_read(5'd7, 32'h55555555, "coll_after");

    // Reset, interrupt the clear at cycle 8, restart; requests during clear are ignored.
    rst = 1'b1;
    step();
    rst     = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_be   = 4'hF;
    wr_data = 32'hFFFFFFFF;
    rd_en   = 1'b1;
    rd_addr = 5'd0;
    for (int c = 0; c < 8; c++) begin
      step();
      check_b($sformatf("mid%0d/busy", c), if1.init_busy, 1'b1);
      check_b($sformatf("mid%0d/l1_valid", c), if1.rd_valid, 1'b0);
      check_b($sformatf("mid%0d/l2_valid", c), if2.rd_valid, 1'b0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_clear("clear1", 1'b1);
    wr_en = 1'b0;
    rd_en = 1'b0;
    do_read(5'd0, 32'h0, "post_clr0");
    do_read(5'd5, 32'h0, "post_clr5");
    do_read(5'd7, 32'h0, "post_clr7");
    do_read(5'd15, 32'h0, "post_clr15");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
